// File: rtl/mult_div_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide controller: op codes,
// FSM states, default timeout and small op-classification helpers.
package mult_div_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MFHI  = 3'd6,
    OP_MFLO  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 40;

  // Codes 0..3 go to the iterative unit; 4..7 only touch HI/LO.
  function automatic logic is_unit_op(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mult_div_timer.sv
// Clearable, saturating wait-cycle counter; terminal flags the cycle whose
// increment brings the count up to LIMIT.
module mult_div_timer #(
  parameter int unsigned LIMIT = 40
) (
  input  logic clk,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic terminal
);

  localparam int unsigned W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count_r;

  assign terminal = (count_r == LAST);

  // Wait-cycle counter, updated on the datapath's falling edge.
  always_ff @(negedge clk) begin
    if (Reset) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en && !terminal) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/mult_div_ctrl.sv
// HI/LO controller sequencing an external iterative multiply/divide unit.
// Optional build macro DIV_ZERO_TRAP_EN: trap divide-by-zero instead of launching.
module mult_div_ctrl
  import mult_div_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        unit_start,
  output logic        unit_div,
  output logic        unit_signed,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  input  logic        unit_done,
  input  logic [31:0] unit_hi,
  input  logic [31:0] unit_lo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_data,
  output logic        stall,
  output logic        err
);

  state_e state_r;
  state_e state_s;
  logic   accept_s;
  logic   trap_s;
  logic   wb_s;
  logic   timeout_s;
  logic   mthi_s;
  logic   mtlo_s;
  logic   timer_clr_s;
  logic   timer_en_s;
  logic   timer_term_s;
  logic   div_zero_s;

`ifdef DIV_ZERO_TRAP_EN
  assign div_zero_s = is_div_op(op) && (rt_val == 32'd0);
`else
  assign div_zero_s = 1'b0;
`endif

  assign stall = op_valid && (state_r != ST_IDLE);

  mult_div_timer #(
    .LIMIT    (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .Reset    (Reset),
    .clr      (timer_clr_s),
    .en       (timer_en_s),
    .terminal (timer_term_s)
  );

  // FSM state register.
  always_ff @(negedge clk) begin
    if (Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    state_s     = state_r;
    accept_s    = 1'b0;
    trap_s      = 1'b0;
    wb_s        = 1'b0;
    timeout_s   = 1'b0;
    mthi_s      = 1'b0;
    mtlo_s      = 1'b0;
    timer_clr_s = 1'b0;
    timer_en_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (op_valid && is_unit_op(op)) begin
          if (div_zero_s) begin
            trap_s  = 1'b1;
            state_s = ST_IDLE;
          end else begin
            accept_s = 1'b1;
            state_s  = ST_LAUNCH;
          end
        end else if (op_valid) begin
          mthi_s  = (op == OP_MTHI);
          mtlo_s  = (op == OP_MTLO);
          state_s = ST_IDLE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        timer_clr_s = 1'b1;
        state_s     = ST_WAIT;
      end
      ST_WAIT: begin
        timer_en_s = 1'b1;
        // A completion in the final allowed cycle still beats the timeout.
        if (unit_done) begin
          wb_s    = 1'b1;
          state_s = ST_IDLE;
        end else if (timer_term_s) begin
          timeout_s = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Launch pulse and operand/kind latches, held until the next accept.
  always_ff @(negedge clk) begin
    if (Reset) begin
      unit_start  <= 1'b0;
      unit_div    <= 1'b0;
      unit_signed <= 1'b0;
      unit_a      <= 32'd0;
      unit_b      <= 32'd0;
    end else begin
      unit_start <= accept_s;
      if (accept_s) begin
        unit_div    <= is_div_op(op);
        unit_signed <= is_signed_op(op);
        unit_a      <= rs_val;
        unit_b      <= rt_val;
      end else begin
        unit_div    <= unit_div;
        unit_signed <= unit_signed;
        unit_a      <= unit_a;
        unit_b      <= unit_b;
      end
    end
  end

  // Architectural HI/LO and the sticky fault flag.
  always_ff @(negedge clk) begin
    if (Reset) begin
      hi  <= 32'd0;
      lo  <= 32'd0;
      err <= 1'b0;
    end else begin
      if (wb_s) begin
        hi <= unit_hi;
      end else if (mthi_s) begin
        hi <= rs_val;
      end else begin
        hi <= hi;
      end
      if (wb_s) begin
        lo <= unit_lo;
      end else if (mtlo_s) begin
        lo <= rs_val;
      end else begin
        lo <= lo;
      end
      err <= err || trap_s || timeout_s;
    end
  end

  // Move-from read port.
  always_comb begin
    mf_data = 32'd0;
    case (op)
      OP_MFHI: mf_data = hi;
      OP_MFLO: mf_data = lo;
      default: mf_data = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Self-checking bench for mult_div_ctrl: directed table, randomized ops against
// an architectural HI/LO model, and hand-written multi-cycle corner sequences.
module tb_mult_div_ctrl;
  import mult_div_ctrl_pkg::*;

  localparam int unsigned TO = 40;

  logic        clk = 1'b0;
  logic        Reset, op_valid, unit_done;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val, unit_hi, unit_lo;
  logic        unit_start, unit_div, unit_signed, stall, err;
  logic [31:0] unit_a, unit_b, hi, lo, mf_data;

  logic        n_rst, n_valid, n_done;
  logic [2:0]  n_op;
  logic [31:0] n_rs, n_rt, n_uhi, n_ulo;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mult_div_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .Reset(Reset), .op_valid(op_valid), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .unit_start(unit_start),
    .unit_div(unit_div), .unit_signed(unit_signed), .unit_a(unit_a),
    .unit_b(unit_b), .unit_done(unit_done), .unit_hi(unit_hi),
    .unit_lo(unit_lo), .hi(hi), .lo(lo), .mf_data(mf_data),
    .stall(stall), .err(err)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  // Inputs change just after the rising edge; DUT acts on the falling edge.
  task automatic step();
    @(posedge clk);
    Reset     = n_rst;
    op_valid  = n_valid;
    op        = n_op;
    rs_val    = n_rs;
    rt_val    = n_rt;
    unit_done = n_done;
    unit_hi   = n_uhi;
    unit_lo   = n_ulo;
    n_rst     = 1'b0;
    n_done    = 1'b0;
    #1;
  endtask

  task automatic issue(input logic v, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    n_valid = v;
    n_op    = o;
    n_rs    = a;
    n_rt    = b;
    step();
  endtask

  // Reference arithmetic: {hi, lo} of the MIPS-style mult/div result.
  function automatic logic [63:0] arith(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    int              sq, sr;
    case (o)
      OP_MULT:  begin sp = longint'($signed(a)) * longint'($signed(b)); return sp; end
      OP_MULTU: begin up = {32'd0, a} * {32'd0, b}; return up; end
      OP_DIV:   begin sq = $signed(a) / $signed(b); sr = $signed(a) % $signed(b); return {sr, sq}; end
      default:  return {a % b, a / b};
    endcase
  endfunction

  // Accept an op, play the unit for lat wait cycles, returning {uh, ul}.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] uh, input logic [31:0] ul);
    issue(1'b1, o, a, b);
    chk1("accept_stall", stall, 1'b0);
    for (int i = 1; i <= lat + 1; i++) begin
      n_done = (i == lat + 1);
      n_uhi  = uh;
      n_ulo  = ul;
      issue(1'b1, 3'($urandom_range(0, 7)), $urandom, $urandom);
      chk1("busy_stall", stall, 1'b1);
      chk("hold_a", unit_a, a);
      chk("hold_b", unit_b, b);
      if (i == 1) begin
        chk1("launch_start", unit_start, 1'b1);
        chk1("unit_div", unit_div, (o == OP_DIV) || (o == OP_DIVU));
        chk1("unit_signed", unit_signed, (o == OP_MULT) || (o == OP_DIV));
      end else begin
        chk1("start_once", unit_start, 1'b0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] r;
    logic [31:0] mhi, mlo, a, b;
    logic [2:0]  o;
    int          n;
    logic        err_early;

    Reset = 1'b1; op_valid = 1'b0; op = 3'd0; rs_val = 32'd0; rt_val = 32'd0;
    unit_done = 1'b0; unit_hi = 32'd0; unit_lo = 32'd0;
    n_rst = 1'b1; n_valid = 1'b0; n_done = 1'b0; n_op = 3'd0;
    n_rs = 32'd0; n_rt = 32'd0; n_uhi = 32'd0; n_ulo = 32'd0;

    tbl[0] = '{OP_MULT,  32'd3,        32'hFFFFFFFE, 33, 32'hFFFFFFFF, 32'hFFFFFFFA};
    tbl[1] = '{OP_MULTU, 32'd3,        32'hFFFFFFFE, 1,  32'h00000002, 32'hFFFFFFFA};
    tbl[2] = '{OP_DIV,   32'd7,        32'd2,        5,  32'h00000001, 32'h00000003};
    tbl[3] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        2,  32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[4] = '{OP_DIVU,  32'hFFFFFFF9, 32'd2,        7,  32'h00000001, 32'h7FFFFFFC};
    tbl[5] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 3,  32'hFFFFFFFE, 32'h00000001};

    // Reset, with a request present to show reset dominates.
    n_rst = 1'b1; issue(1'b1, OP_MULT, 32'd5, 32'd6);
    n_rst = 1'b1; issue(1'b1, OP_MTHI, 32'd9, 32'd0);
    issue(1'b1, OP_MFHI, 32'd0, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_start", unit_start, 1'b0);
    chk1("rst_stall", stall, 1'b0);
    chk("rst_unit_a", unit_a, 32'd0);
    chk("rst_mf", mf_data, 32'd0);

    // Directed table.
    foreach (tbl[k]) begin
      r = arith(tbl[k].op, tbl[k].a, tbl[k].b);
      run_op(tbl[k].op, tbl[k].a, tbl[k].b, tbl[k].lat, r[63:32], r[31:0]);
      issue(1'b0, OP_MULT, 32'd0, 32'd0);
      chk("tbl_hi", hi, tbl[k].ehi);
      chk("tbl_lo", lo, tbl[k].elo);
      chk1("tbl_err", err, 1'b0);
    end

    // Randomized ops against the architectural HI/LO model.
    mhi = hi;
    mlo = lo;
    for (int it = 0; it < 40; it++) begin
      issue(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
      chk("rnd_hi", hi, mhi);
      chk("rnd_lo", lo, mlo);
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      if (o < 3'd4) begin
        if ((o == OP_DIV || o == OP_DIVU) && b == 32'd0) b = 32'd1;
        if (o == OP_DIV && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
        r = arith(o, a, b);
        run_op(o, a, b, $urandom_range(1, 12), r[63:32], r[31:0]);
        mhi = r[63:32];
        mlo = r[31:0];
      end else begin
        issue(1'b1, o, a, b);
        chk1("rnd_idle_stall", stall, 1'b0);
        if (o == OP_MFHI) chk("rnd_mfhi", mf_data, mhi);
        else if (o == OP_MFLO) chk("rnd_mflo", mf_data, mlo);
        else chk("rnd_mt_mf", mf_data, 32'd0);
        if (o == OP_MTHI) mhi = a;
        if (o == OP_MTLO) mlo = a;
      end
    end
    chk1("rnd_err", err, 1'b0);

    // MTHI then MFHI the following cycle.
    issue(1'b1, OP_MTHI, 32'h00001234, 32'd0);
    chk1("mthi_stall", stall, 1'b0);
    issue(1'b1, OP_MFHI, 32'd0, 32'd0);
    chk("mfhi_after_mthi", mf_data, 32'h00001234);
    chk1("mfhi_stall", stall, 1'b0);

    // MFLO held off during WAIT until the cycle after completion.
    issue(1'b1, OP_MULTU, 32'd5, 32'd7);
    for (int i = 1; i <= 5; i++) begin
      n_done = (i == 5); n_uhi = 32'd0; n_ulo = 32'd35;
      issue(1'b1, OP_MFLO, 32'd0, 32'd0);
      chk1("mflo_wait_stall", stall, 1'b1);
    end
    issue(1'b1, OP_MFLO, 32'd0, 32'd0);
    chk1("mflo_release", stall, 1'b0);
    chk("mflo_new_lo", mf_data, 32'd35);

    // unit_done in IDLE and in LAUNCH is ignored.
    n_done = 1'b1; n_uhi = 32'h0000AAAA; n_ulo = 32'h0000BBBB;
    issue(1'b0, OP_MULT, 32'd0, 32'd0);
    issue(1'b0, OP_MULT, 32'd0, 32'd0);
    chk("idle_done_hi", hi, 32'd0);
    chk("idle_done_lo", lo, 32'd35);
    issue(1'b1, OP_MULT, 32'd2, 32'd3);
    n_done = 1'b1; n_uhi = 32'h00001111; n_ulo = 32'h00002222;
    issue(1'b1, OP_MFLO, 32'd0, 32'd0);
    chk1("launch_done_stall", stall, 1'b1);
    issue(1'b1, OP_MFLO, 32'd0, 32'd0);
    chk1("launch_done_ignored", stall, 1'b1);
    n_done = 1'b1; n_uhi = 32'd0; n_ulo = 32'd6;
    issue(1'b1, OP_MFLO, 32'd0, 32'd0);
    issue(1'b1, OP_MFLO, 32'd0, 32'd0);
    chk1("launch_seq_release", stall, 1'b0);
    chk("launch_seq_lo", mf_data, 32'd6);

    // Divide by zero.
    issue(1'b1, OP_DIV, 32'd7, 32'd0);
    chk1("div0_accept_stall", stall, 1'b0);
`ifdef DIV_ZERO_TRAP_EN
    issue(1'b0, OP_MULT, 32'd0, 32'd0);
    chk1("div0_no_start", unit_start, 1'b0);
    chk1("div0_err", err, 1'b1);
    issue(1'b1, OP_MFLO, 32'd0, 32'd0);
    chk1("div0_idle", stall, 1'b0);
    chk("div0_lo", mf_data, 32'd6);
    chk("div0_hi", hi, 32'd0);
`else
    issue(1'b0, OP_MULT, 32'd0, 32'd0);
    chk1("div0_start", unit_start, 1'b1);
    n_done = 1'b1; n_uhi = 32'h0000DEAD; n_ulo = 32'h0000BEEF;
    issue(1'b0, OP_MULT, 32'd0, 32'd0);
    issue(1'b0, OP_MULT, 32'd0, 32'd0);
    chk("div0_hi", hi, 32'h0000DEAD);
    chk("div0_lo", lo, 32'h0000BEEF);
    chk1("div0_err", err, 1'b0);
`endif

    // Timeout with unit_done withheld.
    n_rst = 1'b1; issue(1'b0, OP_MULT, 32'd0, 32'd0);
    issue(1'b1, OP_MULT, 32'd1, 32'd1);
    n = 0;
    err_early = 1'b0;
    for (int i = 0; i < int'(TO) + 5; i++) begin
      issue(1'b1, OP_MFHI, 32'd0, 32'd0);
      if (!stall) break;
      n++;
      if (err) err_early = 1'b1;
    end
    chk("timeout_busy_cycles", 32'(n), 32'(TO + 1));
    chk1("timeout_err_early", err_early, 1'b0);
    chk1("timeout_err", err, 1'b1);
    chk("timeout_hi", hi, 32'd0);
    chk("timeout_lo", lo, 32'd0);

    // Reset in WAIT, then a late unit_done.
    n_rst = 1'b1; issue(1'b0, OP_MULT, 32'd0, 32'd0);
    issue(1'b1, OP_MTLO, 32'h00000077, 32'd0);
    issue(1'b1, OP_MULT, 32'd4, 32'd5);
    issue(1'b0, OP_MULT, 32'd0, 32'd0);
    issue(1'b0, OP_MULT, 32'd0, 32'd0);
    n_rst = 1'b1; issue(1'b1, OP_MTHI, 32'h00000099, 32'd0);
    n_done = 1'b1; n_uhi = 32'h00000055; n_ulo = 32'h00000066;
    issue(1'b0, OP_MULT, 32'd0, 32'd0);
    issue(1'b1, OP_MFLO, 32'd0, 32'd0);
    chk1("rstwait_idle", stall, 1'b0);
    chk("rstwait_hi", hi, 32'd0);
    chk("rstwait_lo", lo, 32'd0);
    chk("rstwait_mf", mf_data, 32'd0);
    chk1("rstwait_err", err, 1'b0);
    chk1("rstwait_start", unit_start, 1'b0);
    chk("rstwait_unit_a", unit_a, 32'd0);
    chk("rstwait_unit_b", unit_b, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
